// File: rtl/la_capture_fsm_if.sv
// Register-bus request/response bundle for la_capture_fsm.
// The slave side registers every request and returns it as the response one cycle later.
interface la_capture_fsm_if;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    modport master (
        output addr_i, data_i, rw_i, valid_i,
        input  addr_o, data_o, rw_o, valid_o
    );

    modport slave (
        input  addr_i, data_i, rw_i, valid_i,
        output addr_o, data_o, rw_o, valid_o
    );
endinterface

// File: rtl/la_capture_fsm.sv
// Logic-analyser capture sequencer: pre/post-trigger sample addressing plus a bus register file.
// Optional feature: define LA_CAPTURE_FSM_TIMESTAMP_EN for the offset-6 trigger timestamp counter.
module la_capture_fsm #(
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned SAMPLE_DEPTH = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            trig,
    la_capture_fsm_if.slave                 bus,
    output logic                            write_enable,
    output logic [$clog2(SAMPLE_DEPTH)-1:0] write_pointer
);
    localparam int unsigned AW = $clog2(SAMPLE_DEPTH);

    localparam logic [15:0] OFF_STATE = 16'd0;
    localparam logic [15:0] OFF_START = 16'd1;
    localparam logic [15:0] OFF_STOP  = 16'd2;
    localparam logic [15:0] OFF_TLOC  = 16'd3;
    localparam logic [15:0] OFF_RPTR  = 16'd4;
    localparam logic [15:0] OFF_WPTR  = 16'd5;
`ifdef LA_CAPTURE_FSM_TIMESTAMP_EN
    localparam logic [15:0] OFF_TSTAMP = 16'd6;
    localparam logic [15:0] N_REGS     = 16'd7;
`else
    localparam logic [15:0] N_REGS     = 16'd6;
`endif

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_write_enable;
    logic [AW-1:0]   r_write_pointer;
    logic [AW-1:0]   r_read_pointer;
    logic [AW-1:0]   r_trigger_loc;
    logic [15:0]     r_addr_o;
    logic [15:0]     r_data_o;
    logic            r_rw_o;
    logic            r_valid_o;
`ifdef LA_CAPTURE_FSM_TIMESTAMP_EN
    logic [15:0]     r_timestamp;
`endif

    logic [15:0]     w_offset;
    logic            w_owned;
    logic            w_wr;
    logic            w_rd;
    logic            w_start;
    logic            w_stop;
    logic            w_tloc_wr;
    logic [AW-1:0]   w_tloc_clamped;
    logic [AW-1:0]   w_tloc_minus1;
    logic [AW-1:0]   w_rptr_minus1;
    logic [15:0]     w_rdata;

    assign w_offset  = bus.addr_i - 16'(BASE_ADDR);
    assign w_owned   = (32'(bus.addr_i) >= BASE_ADDR) && (w_offset < N_REGS);
    assign w_wr      = bus.valid_i && bus.rw_i && w_owned;
    assign w_rd      = bus.valid_i && !bus.rw_i && w_owned;
    assign w_start   = w_wr && (w_offset == OFF_START) && bus.data_i[0];
    assign w_stop    = w_wr && (w_offset == OFF_STOP) && bus.data_i[0];
    assign w_tloc_wr = w_wr && (w_offset == OFF_TLOC);

    assign w_tloc_clamped = (32'(bus.data_i) > (SAMPLE_DEPTH - 1)) ? AW'(SAMPLE_DEPTH - 1)
                                                                   : bus.data_i[AW-1:0];
    assign w_tloc_minus1  = r_trigger_loc - AW'(1);
    assign w_rptr_minus1  = r_read_pointer - AW'(1);

    always_comb begin
        w_rdata = '0;
        case (w_offset)
            OFF_STATE:  w_rdata = 16'(r_state);
            OFF_TLOC:   w_rdata = 16'(r_trigger_loc);
            OFF_RPTR:   w_rdata = 16'(r_read_pointer);
            OFF_WPTR:   w_rdata = 16'(r_write_pointer);
`ifdef LA_CAPTURE_FSM_TIMESTAMP_EN
            OFF_TSTAMP: w_rdata = r_timestamp;
`endif
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_write_enable  <= 1'b0;
            r_write_pointer <= '0;
            r_read_pointer  <= '0;
            r_trigger_loc   <= '0;
            r_addr_o        <= '0;
            r_data_o        <= '0;
            r_rw_o          <= 1'b0;
            r_valid_o       <= 1'b0;
        end else begin
            r_addr_o  <= bus.addr_i;
            r_data_o  <= w_rd ? w_rdata : bus.data_i;
            r_rw_o    <= bus.rw_i;
            r_valid_o <= bus.valid_i;

            if (w_stop) begin
                r_state        <= IDLE;
                r_write_enable <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_tloc_wr) begin
                            r_trigger_loc <= w_tloc_clamped;
                        end
                        if (w_start) begin
                            r_write_pointer <= '0;
                            r_read_pointer  <= '0;
                            r_write_enable  <= 1'b1;
                            r_state         <= (r_trigger_loc == '0) ? IN_POSITION : MOVE_TO_POSITION;
                        end
                    end
                    MOVE_TO_POSITION: begin
                        r_write_pointer <= r_write_pointer + AW'(1);
                        if (r_write_pointer == w_tloc_minus1) begin
                            r_state <= IN_POSITION;
                        end
                    end
                    IN_POSITION: begin
                        r_write_pointer <= r_write_pointer + AW'(1);
                        // read_pointer now marks the oldest sample; capture ends when the ring is full
                        if (trig) begin
                            if (r_write_pointer == w_rptr_minus1) begin
                                r_state        <= CAPTURED;
                                r_write_enable <= 1'b0;
                            end else begin
                                r_state <= CAPTURING;
                            end
                        end else begin
                            r_read_pointer <= r_read_pointer + AW'(1);
                        end
                    end
                    CAPTURING: begin
                        r_write_pointer <= r_write_pointer + AW'(1);
                        if (r_write_pointer == w_rptr_minus1) begin
                            r_state        <= CAPTURED;
                            r_write_enable <= 1'b0;
                        end
                    end
                    CAPTURED: begin
                        r_write_enable <= 1'b0;
                    end
                    default: begin
                        r_state        <= IDLE;
                        r_write_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LA_CAPTURE_FSM_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timestamp <= '0;
        end else if (!w_stop) begin
            if ((r_state == IDLE) && w_start) begin
                r_timestamp <= '0;
            end else if ((r_state == IN_POSITION) && !trig && (r_timestamp != 16'hFFFF)) begin
                r_timestamp <= r_timestamp + 16'd1;
            end
        end
    end
`endif

    assign write_enable  = r_write_enable;
    assign write_pointer = r_write_pointer;
    assign bus.addr_o    = r_addr_o;
    assign bus.data_o    = r_data_o;
    assign bus.rw_o      = r_rw_o;
    assign bus.valid_o   = r_valid_o;

endmodule

// File: tb/tb_la_capture_fsm.sv
// Directed self-checking bench for la_capture_fsm at SAMPLE_DEPTH=8, BASE_ADDR=0.
// Each monitored cycle reads the state register, so state/write_enable/write_pointer line up per cycle.
module tb_la_capture_fsm;
    logic       clk;
    logic       rst;
    logic       trig;
    logic       write_enable;
    logic [2:0] write_pointer;

    la_capture_fsm_if bus_if ();

    la_capture_fsm #(
        .BASE_ADDR    (0),
        .SAMPLE_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trig          (trig),
        .bus           (bus_if),
        .write_enable  (write_enable),
        .write_pointer (write_pointer)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int est [16];
    int ewp [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the test");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic v, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        trig           = t;
        bus_if.valid_i = v;
        bus_if.rw_i    = w;
        bus_if.addr_i  = a;
        bus_if.data_i  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        drive(1'b0, 1'b1, 1'b1, a, d);
        tick();
        idle();
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] q);
        drive(1'b0, 1'b1, 1'b0, a, 16'h0);
        tick();
        q = bus_if.data_o;
        idle();
    endtask

    // Observe one cycle: outputs now, and the state register as read during that same cycle.
    task automatic mon(input logic t, output logic [2:0] st, output logic we, output logic [2:0] wp);
        we = write_enable;
        wp = write_pointer;
        drive(t, 1'b1, 1'b0, 16'h0, 16'h0);
        tick();
        st = bus_if.data_o[2:0];
        idle();
    endtask

    task automatic scenario(input string nm, input int n, input int t1, input int t2,
                            output int we_after_trig);
        logic [2:0] st;
        logic       we;
        logic [2:0] wp;
        logic       we_exp;
        we_after_trig = 0;
        for (int c = 1; c <= n; c++) begin
            mon((c == t1) || (c == t2), st, we, wp);
            we_exp = (est[c-1] inside {1, 2, 3});
            check($sformatf("%s c%0d state", nm, c), 32'(st), 32'(est[c-1]));
            check($sformatf("%s c%0d we", nm, c), 32'(we), 32'(we_exp));
            if (we_exp) begin
                check($sformatf("%s c%0d wp", nm, c), 32'(wp), 32'(ewp[c-1]));
            end
            if ((t1 != 0) && (c >= t1) && we) begin
                we_after_trig++;
            end
        end
    endtask

    initial begin
        logic [15:0] q;
        logic [2:0]  st;
        logic        we;
        logic [2:0]  wp;
        int          nwe;

        rst = 1'b1;
        idle();
        tick();
        tick();
        check("rst we", 32'(write_enable), 32'd0);
        check("rst wp", 32'(write_pointer), 32'd0);
        check("rst addr_o", 32'(bus_if.addr_o), 32'd0);
        check("rst data_o", 32'(bus_if.data_o), 32'd0);
        check("rst rw_o", 32'(bus_if.rw_o), 32'd0);
        check("rst valid_o", 32'(bus_if.valid_o), 32'd0);
        rst = 1'b0;
        bus_rd(16'd0, q);
        check("rst state", 32'(q), 32'd0);
        bus_rd(16'd3, q);
        check("rst tloc", 32'(q), 32'd0);

        // trigger_loc=3, trig 10 cycles after start
        bus_wr(16'd3, 16'd3);
        bus_rd(16'd3, q);
        check("a tloc", 32'(q), 32'd3);
        bus_wr(16'd1, 16'd1);
        est = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4};
        ewp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 0, 0};
        scenario("a", 16, 10, 0, nwe);
        check("a writes from trig", 32'(nwe), 32'd5);
        bus_rd(16'd4, q);
        check("a rptr", 32'(q), 32'd6);
        bus_wr(16'd3, 16'd5);
        bus_rd(16'd3, q);
        check("a tloc locked", 32'(q), 32'd3);
        bus_wr(16'd1, 16'd1);
        mon(1'b0, st, we, wp);
        check("a start in captured st", 32'(st), 32'd4);
        check("a start in captured we", 32'(we), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 16'd0, 16'hA5A5);
        tick();
        check("ro write data_o", 32'(bus_if.data_o), 32'hA5A5);
        check("ro write rw_o", 32'(bus_if.rw_o), 32'd1);
        idle();
        bus_wr(16'd2, 16'd1);
        check("a stop we", 32'(write_enable), 32'd0);
        bus_rd(16'd0, q);
        check("a stop state", 32'(q), 32'd0);
        bus_rd(16'd4, q);
        check("a stop rptr hold", 32'(q), 32'd6);

        // trigger_loc=0, trig on first IN_POSITION cycle
        bus_wr(16'd3, 16'd0);
        bus_wr(16'd1, 16'd1);
        est = '{2, 3, 3, 3, 3, 3, 3, 3, 4, 0, 0, 0, 0, 0, 0, 0};
        ewp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        scenario("b", 9, 1, 0, nwe);
        check("b writes", 32'(nwe), 32'd8);
        bus_rd(16'd4, q);
        check("b rptr", 32'(q), 32'd0);
        bus_wr(16'd2, 16'd1);

        // clamp to 7, trig ignored in MOVE_TO_POSITION, ring already full at trig
        bus_wr(16'd3, 16'd20);
        bus_rd(16'd3, q);
        check("c tloc clamp", 32'(q), 32'd7);
        bus_wr(16'd1, 16'd1);
        est = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 4, 0, 0, 0, 0, 0};
        ewp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 0, 0, 0, 0, 0, 0};
        scenario("c", 11, 3, 10, nwe);
        bus_rd(16'd4, q);
        check("c rptr", 32'(q), 32'd2);
        bus_wr(16'd2, 16'd1);

        // stop and trig together in IN_POSITION
        bus_wr(16'd3, 16'd2);
        bus_wr(16'd1, 16'd1);
        est = '{1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ewp = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        scenario("d", 4, 0, 0, nwe);
        check("d wp before stop", 32'(write_pointer), 32'd4);
        drive(1'b1, 1'b1, 1'b1, 16'd2, 16'd1);
        tick();
        idle();
        check("d stop we", 32'(write_enable), 32'd0);
        check("d stop wp hold", 32'(write_pointer), 32'd4);
        for (int k = 0; k < 3; k++) begin
            mon(1'b1, st, we, wp);
            check($sformatf("d trig ignored %0d st", k), 32'(st), 32'd0);
            check($sformatf("d trig ignored %0d we", k), 32'(we), 32'd0);
        end
        bus_rd(16'd4, q);
        check("d rptr hold", 32'(q), 32'd2);

        // reset in CAPTURING, with a bus request in the same cycle
        bus_wr(16'd3, 16'd1);
        bus_wr(16'd1, 16'd1);
        est = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ewp = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        scenario("e", 3, 2, 0, nwe);
        check("e we before rst", 32'(write_enable), 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'd5, 16'hABCD);
        tick();
        rst = 1'b0;
        idle();
        check("e rst we", 32'(write_enable), 32'd0);
        check("e rst wp", 32'(write_pointer), 32'd0);
        check("e rst addr_o", 32'(bus_if.addr_o), 32'd0);
        check("e rst data_o", 32'(bus_if.data_o), 32'd0);
        check("e rst valid_o", 32'(bus_if.valid_o), 32'd0);
        bus_rd(16'd0, q);
        check("e state", 32'(q), 32'd0);
        bus_rd(16'd3, q);
        check("e tloc", 32'(q), 32'd0);
        bus_rd(16'd4, q);
        check("e rptr", 32'(q), 32'd0);

        // passthrough of unowned and non-valid traffic
        drive(1'b0, 1'b1, 1'b1, 16'd9, 16'h1234);
        tick();
        check("pt wr addr_o", 32'(bus_if.addr_o), 32'd9);
        check("pt wr data_o", 32'(bus_if.data_o), 32'h1234);
        check("pt wr rw_o", 32'(bus_if.rw_o), 32'd1);
        check("pt wr valid_o", 32'(bus_if.valid_o), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h5555);
        tick();
        check("pt rd data_o", 32'(bus_if.data_o), 32'h5555);
        check("pt rd rw_o", 32'(bus_if.rw_o), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'd3, 16'hBEEF);
        tick();
        check("pt invalid data_o", 32'(bus_if.data_o), 32'hBEEF);
        check("pt invalid valid_o", 32'(bus_if.valid_o), 32'd0);
        idle();

`ifdef LA_CAPTURE_FSM_TIMESTAMP_EN
        bus_wr(16'd3, 16'd0);
        bus_wr(16'd1, 16'd1);
        est = '{2, 2, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ewp = '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        scenario("f", 7, 6, 0, nwe);
        bus_rd(16'd6, q);
        check("f timestamp", 32'(q), 32'd5);
        bus_wr(16'd2, 16'd1);
`else
        drive(1'b0, 1'b1, 1'b0, 16'd6, 16'h6666);
        tick();
        check("off6 passthrough", 32'(bus_if.data_o), 32'h6666);
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
